// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch stage
package ifetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } ifetch_state_t;

    localparam logic [31:0] PC_INC                 = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC       = 32'h0000_0000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_watchdog.sv
// rtl/ifetch_watchdog.sv - counts consecutive unanswered memory request cycles
module ifetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_waiting,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Expiry fires during the last permitted waiting cycle so the fetch stage
    // can abandon the request on the same edge the limit is reached.
    assign o_expired = i_waiting && (r_count == CW'(TIMEOUT_CYCLES - 1));

    // Count waiting cycles; any cycle without a pending request restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_waiting || o_expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: pc, memory req/ack, IR latch, redirects; IFETCH_TIMEOUT_EN adds a watchdog
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        ir_consume,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] IR,
    output logic        IR_valid,
    output logic [31:0] IR_pc,
    output logic        align_fault,
    output logic        fetch_error
);

    ifetch_state_t r_state;
    logic [31:0]   r_pc;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_ir;
    logic          r_ir_valid;
    logic [31:0]   r_ir_pc;
    logic          r_align_fault;
    logic          w_ack;
    logic          w_timeout;
    logic [31:0]   w_target;

    generate
        if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
            $error("RESET_PC must be word aligned");
        end
        if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be non-zero");
        end
    endgenerate

    // An ack only means something while a request is actually on the bus
    assign w_ack    = mem_ack && r_mem_req;
    assign w_target = word_align(branch_target);

`ifdef IFETCH_TIMEOUT_EN
    logic w_waiting;
    logic r_fetch_error;

    assign w_waiting = r_mem_req && !mem_ack;

    ifetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_waiting (w_waiting),
        .o_expired (w_timeout)
    );

    // Sticky error flag; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_error <= 1'b0;
        end else if (w_timeout && !branch_valid) begin
            r_fetch_error <= 1'b1;
        end
    end

    assign fetch_error = r_fetch_error;
`else
    assign w_timeout   = 1'b0;
    assign fetch_error = 1'b0;
`endif

    // Fetch sequencer: a redirect outranks timeout, ack and consume in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_ir          <= '0;
            r_ir_valid    <= 1'b0;
            r_ir_pc       <= '0;
            r_align_fault <= 1'b0;
        end else begin
            r_align_fault <= 1'b0;
            if (branch_valid) begin
                r_pc          <= w_target;
                r_ir_valid    <= 1'b0;
                r_align_fault <= (branch_target[1:0] != 2'b00);
                case (r_state)
                    ST_REQ: begin
                        if (w_ack) begin
                            // Returned word belongs to the old stream: drop it
                            r_state    <= ST_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_target;
                        end else begin
                            // Read still in flight; let it finish at the stale address
                            r_state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        r_state <= ST_DRAIN;
                    end
                    default: begin
                        r_state    <= ST_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_target;
                    end
                endcase
            end else if (w_timeout) begin
                r_state   <= ST_IDLE;
                r_mem_req <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (fetch_en) begin
                            r_state    <= ST_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                        end
                    end
                    ST_REQ: begin
                        if (w_ack) begin
                            r_ir       <= mem_rdata;
                            r_ir_pc    <= r_pc;
                            r_ir_valid <= 1'b1;
                            r_pc       <= r_pc + PC_INC;
                            r_mem_req  <= 1'b0;
                            r_state    <= ST_HOLD;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_ack) begin
                            // Stale word discarded; request continues at the redirected pc
                            r_state    <= ST_REQ;
                            r_mem_addr <= r_pc;
                        end
                    end
                    ST_HOLD: begin
                        if (ir_consume) begin
                            r_ir_valid <= 1'b0;
                            if (fetch_en) begin
                                r_state    <= ST_REQ;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= r_pc;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign IR          = r_ir;
    assign IR_valid    = r_ir_valid;
    assign IR_pc       = r_ir_pc;
    assign align_fault = r_align_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
`timescale 1ns/1ps
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        ir_consume;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] IR;
    logic        IR_valid;
    logic [31:0] IR_pc;
    logic        align_fault;
    logic        fetch_error;

    logic        w_fetch_en;
    logic        w_consume;
    logic        w_branch;
    logic [31:0] w_target;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_ir;
    logic        w_ir_valid;
    logic [31:0] w_ir_pc;
    logic        w_align;
    logic        w_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_wait;
    bit          mem_hang;
    int          discard_pending;
    int          wait_cnt;
    int          align_cnt = 0;
    int          waited;
    int          valid_cnt;
    sb_t         sb_q[$];
    logic [31:0] wrap_addrs[$];

    instruction_fetch #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .ir_consume    (ir_consume),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .IR            (IR),
        .IR_valid      (IR_valid),
        .IR_pc         (IR_pc),
        .align_fault   (align_fault),
        .fetch_error   (fetch_error)
    );

    instruction_fetch #(
        .RESET_PC       (32'hFFFF_FFFC),
        .TIMEOUT_CYCLES (16)
    ) u_wrap (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (w_fetch_en),
        .ir_consume    (w_consume),
        .branch_valid  (w_branch),
        .branch_target (w_target),
        .mem_req       (w_mem_req),
        .mem_addr      (w_mem_addr),
        .mem_ack       (w_mem_ack),
        .mem_rdata     (w_rdata),
        .IR            (w_ir),
        .IR_valid      (w_ir_valid),
        .IR_pc         (w_ir_pc),
        .align_fault   (w_align),
        .fetch_error   (w_err)
    );

    assign w_mem_ack = w_mem_req;
    assign w_rdata   = ~w_mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'hDEAD_BEEF : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!IR_valid && n < 50) begin
            step();
            n++;
        end
        check_eq({tag, "_valid_to"}, {31'b0, IR_valid}, 32'd1);
    endtask

    // Memory model: acks after mem_wait stalled cycles, pushes kept words to the scoreboard
    initial begin
        mem_ack  = 1'b0;
        mem_rdata = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_hang && wait_cnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = word_of(mem_addr);
                if (discard_pending > 0) discard_pending--;
                else sb_q.push_back('{pc: mem_addr, word: word_of(mem_addr)});
                wait_cnt = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wait_cnt  = mem_req ? wait_cnt + 1 : 0;
            end
        end
    end

    // Scoreboard monitor: every fresh IR_valid must match the oldest kept read
    initial begin
        bit prev_valid;
        sb_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (IR_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("ir_pc", IR_pc, e.pc);
                    check_eq("ir_word", IR, e.word);
                end
            end
            prev_valid = IR_valid;
            if (align_fault) align_cnt++;
        end
    end

    // Address log of the wrap-around instance after the first reset release
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && w_mem_req && wrap_addrs.size() < 2) wrap_addrs.push_back(w_mem_addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; fetch_en = 1'b0; ir_consume = 1'b0;
        branch_valid = 1'b0; branch_target = '0;
        mem_wait = 0; mem_hang = 1'b0; discard_pending = 0;
        w_fetch_en = 1'b1; w_consume = 1'b1; w_branch = 1'b0; w_target = '0;
        repeat (3) step();

        check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_ir", IR, 32'h0);
        check_eq("rst_ir_valid", {31'b0, IR_valid}, 32'd0);
        check_eq("rst_ir_pc", IR_pc, 32'h0);
        check_eq("rst_align", {31'b0, align_fault}, 32'd0);
        check_eq("rst_fetch_error", {31'b0, fetch_error}, 32'd0);

        // First fetch, zero-wait memory
        reset = 1'b0; fetch_en = 1'b1;
        step();
        check_eq("t1_req", {31'b0, mem_req}, 32'd1);
        check_eq("t1_addr", mem_addr, 32'h0);
        step();
        check_eq("t1_valid", {31'b0, IR_valid}, 32'd1);
        check_eq("t1_ir", IR, 32'hDEAD_BEEF);
        check_eq("t1_ir_pc", IR_pc, 32'h0);
        step();
        check_eq("t1_hold_ir", IR, 32'hDEAD_BEEF);
        check_eq("t1_hold_req", {31'b0, mem_req}, 32'd0);

        // Three stalled cycles at address 4
        mem_wait = 3; ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_stall_addr", mem_addr, 32'h4);
            check_eq("t2_stall_req", {31'b0, mem_req}, 32'd1);
            check_eq("t2_stall_valid", {31'b0, IR_valid}, 32'd0);
            step();
        end
        wait_valid("t2");

        // Redirect while the read at 8 is outstanding
        ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;
        check_eq("t3_addr8", mem_addr, 32'h8);
        branch_valid = 1'b1; branch_target = 32'h100; discard_pending = 1;
        step();
        branch_valid = 1'b0;
        check_eq("t3_drain_addr", mem_addr, 32'h8);
        check_eq("t3_drain_req", {31'b0, mem_req}, 32'd1);
        check_eq("t3_no_align", {31'b0, align_fault}, 32'd0);
        for (int i = 0; i < 20 && !(mem_req && mem_addr == 32'h100); i++) step();
        check_eq("t3_redirect_addr", mem_addr, 32'h100);
        wait_valid("t3");

        // Misaligned branch together with consume
        mem_wait = 0; ir_consume = 1'b1; branch_valid = 1'b1; branch_target = 32'h102;
        step();
        ir_consume = 1'b0; branch_valid = 1'b0;
        check_eq("t4_align", {31'b0, align_fault}, 32'd1);
        check_eq("t4_addr", mem_addr, 32'h100);
        check_eq("t4_req", {31'b0, mem_req}, 32'd1);
        check_eq("t4_valid_cleared", {31'b0, IR_valid}, 32'd0);
        step();
        check_eq("t4_align_done", {31'b0, align_fault}, 32'd0);
        wait_valid("t4");

        // Consume with fetch disabled parks in IDLE
        ir_consume = 1'b1; fetch_en = 1'b0;
        step();
        ir_consume = 1'b0;
        check_eq("t5_idle_req", {31'b0, mem_req}, 32'd0);
        check_eq("t5_idle_valid", {31'b0, IR_valid}, 32'd0);
        step();
        check_eq("t5_idle_req2", {31'b0, mem_req}, 32'd0);
        fetch_en = 1'b1;
        step();
        check_eq("t5_resume_addr", mem_addr, 32'h104);
        check_eq("t5_resume_req", {31'b0, mem_req}, 32'd1);
        wait_valid("t5");

        // Memory never answers the read at 0x108
        mem_hang = 1'b1; ir_consume = 1'b1;
        step();
        ir_consume = 1'b0;
        check_eq("t6_addr", mem_addr, 32'h108);
`ifdef IFETCH_TIMEOUT_EN
        waited = 0;
        for (int i = 0; i < 40 && !fetch_error; i++) begin
            if (mem_req) waited++;
            step();
        end
        check_eq("t6_error_set", {31'b0, fetch_error}, 32'd1);
        check_eq("t6_wait_cycles", waited, 32'd16);
        check_eq("t6_req_dropped", {31'b0, mem_req}, 32'd0);
        fetch_en = 1'b0;
        step();
        check_eq("t6_error_sticky", {31'b0, fetch_error}, 32'd1);
        check_eq("t6_idle_req", {31'b0, mem_req}, 32'd0);
`else
        repeat (20) step();
        check_eq("t6_no_error", {31'b0, fetch_error}, 32'd0);
        check_eq("t6_still_req", {31'b0, mem_req}, 32'd1);
        check_eq("t6_still_addr", mem_addr, 32'h108);
`endif

        // Reset mid-operation aborts the hung read
        reset = 1'b1; fetch_en = 1'b0;
        step();
        mem_hang = 1'b0;
        check_eq("t7_rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("t7_rst_error", {31'b0, fetch_error}, 32'd0);
        check_eq("t7_rst_valid", {31'b0, IR_valid}, 32'd0);
        check_eq("t7_rst_addr", mem_addr, 32'h0);

        // Back-to-back throughput: one instruction every two cycles
        reset = 1'b0; fetch_en = 1'b1; ir_consume = 1'b1;
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 1) check_eq("t8_first_valid", {31'b0, IR_valid}, 32'd1);
            if (IR_valid) valid_cnt++;
        end
        ir_consume = 1'b0;
        check_eq("t8_throughput", valid_cnt, 32'd5);
        repeat (3) step();
        check_eq("t8_sb_empty", sb_q.size(), 32'd0);

        // Wrap instance: RESET_PC at the top of the address space
        check_eq("wrap_cnt", wrap_addrs.size(), 32'd2);
        if (wrap_addrs.size() >= 2) begin
            check_eq("wrap_addr0", wrap_addrs[0], 32'hFFFF_FFFC);
            check_eq("wrap_addr1", wrap_addrs[1], 32'h0);
        end
        check_eq("align_pulses", align_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
